// File: rtl/gf2m_pkg.sv
// Shared constants, state encoding and helpers for the GF(2^m) power S-box engine.
package gf2m_pkg;

  localparam int          W_DEF        = 6;
  localparam int          EXP_W_DEF    = 6;
  localparam logic [6:0]  POLY_DEF     = 7'h43;
  localparam logic [5:0]  ADD_MASK_DEF = 6'h14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic parity_mask(
    input logic [31:0] v,
    input logic [31:0] m
  );
    return ^(v & m);
  endfunction

endpackage

// File: rtl/gf2m_mul.sv
// Combinational polynomial-basis multiplier over GF(2^W) reduced by POLY.
module gf2m_mul #(
  parameter int       W    = 6,
  parameter logic [W:0] POLY = 7'h43
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c
);

  // Horner form: MSB of b first, multiply-by-x then conditional add of a.
  always_comb begin
    c = '0;
    for (int i = W - 1; i >= 0; i--) begin
      c = {c[W-2:0], 1'b0} ^ (c[W-1] ? POLY[W-1:0] : '0);
      c = c ^ (b[i] ? a : '0);
    end
  end

endmodule

// File: rtl/gf2m_pow_sbox_seq.sv
// Iterative square-and-multiply S-box: y = x^e ^ optional broadcast parity term.
module gf2m_pow_sbox_seq
  import gf2m_pkg::*;
#(
  parameter int           W        = W_DEF,
  parameter int           EXP_W    = EXP_W_DEF,
  parameter logic [W:0]   POLY     = POLY_DEF,
  parameter logic [W-1:0] ADD_MASK = ADD_MASK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [EXP_W-1:0] e,
  input  logic             add_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic             busy
);

  localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_x;
  logic [EXP_W-1:0] r_e;
  logic             r_add;
  logic [W-1:0]     r_y;

  logic [W-1:0]     w_sq;
  logic [W-1:0]     w_mb;
  logic [W-1:0]     w_step;
  logic [W-1:0]     w_aff;

  assign w_mb  = r_e[r_cnt] ? r_x : W'(1);
  assign w_aff = {W{r_add & parity_mask(32'(r_x), 32'(ADD_MASK))}};

  gf2m_mul #(.W(W), .POLY(POLY)) u_sq (
    .a(r_acc),
    .b(r_acc),
    .c(w_sq)
  );

  gf2m_mul #(.W(W), .POLY(POLY)) u_mul (
    .a(w_sq),
    .b(w_mb),
    .c(w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)      w_state_nxt = RUN;
      RUN:     if (r_cnt == '0)   w_state_nxt = DONE;
      DONE:    if (out_ready)     w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= W'(1);
      r_cnt   <= '0;
      r_x     <= '0;
      r_e     <= '0;
      r_add   <= 1'b0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= x;
            r_e   <= e;
            r_add <= add_en;
            r_acc <= W'(1);
            r_cnt <= CNT_W'(EXP_W - 1);
          end
        end
        RUN: begin
          r_acc <= w_step;
          if (r_cnt == '0) r_y   <= w_step ^ w_aff;
          else             r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign y         = r_y;

endmodule

// File: tb/tb_gf2m_pow_sbox_seq.sv
// Directed checks of the iterative GF(2^6) power S-box engine.
module tb_gf2m_pow_sbox_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] x;
  logic [5:0] e;
  logic       add_en;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] y;
  logic       busy;

  int n_chk;
  int n_fail;

  gf2m_pow_sbox_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .e        (e),
    .add_en   (add_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // LSB-first shift-and-add reference multiply (x^6 = x + 1)
  function automatic logic [5:0] gmul(input logic [5:0] a,
                                      input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] gpow(input logic [5:0] b,
                                      input int n);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < n; i++) r = gmul(r, b);
    return r;
  endfunction

  task automatic txn(input logic [5:0] xi, input logic [5:0] ei,
                     input logic ai, output logic [5:0] yo,
                     output int lat, output logic rdy_seen);
    in_valid = 1'b1;
    x        = xi;
    e        = ei;
    add_en   = ai;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    yo        = y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [5:0] r;
  int         lat;
  logic       rs;
  logic       ov_seen;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    e         = '0;
    add_en    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);

    txn(6'h20, 6'd2, 1'b0, r, lat, rs);
    check("sq_20", r, 6'h30);
    check("latency", lat, 6);
    check("no_ready_in_run", rs, 0);

    txn(6'h02, 6'd62, 1'b0, r, lat, rs);
    check("inv_02", r, 6'h21);
    txn(6'h02, 6'd62, 1'b1, r, lat, rs);
    check("inv_02_aff", r, 6'h21);
    txn(6'h04, 6'd1, 1'b1, r, lat, rs);
    check("aff_flip", r, 6'h3B);
    txn(6'h00, 6'd0, 1'b0, r, lat, rs);
    check("zero_e0", r, 6'h01);
    txn(6'h00, 6'd52, 1'b0, r, lat, rs);
    check("zero_e52", r, 6'h00);
    txn(6'h2D, 6'd63, 1'b0, r, lat, rs);
    check("e63_2d", r, 6'h01);

    for (int i = 1; i < 64; i++) begin
      txn(6'(i), 6'd63, 1'b0, r, lat, rs);
      check($sformatf("e63_x%0h", i), r, 6'h01);
    end

    for (int i = 0; i < 64; i++) begin
      logic [5:0] xv;
      logic [5:0] ex;
      xv = 6'(i);
      ex = gpow(xv, 52) ^ {6{^(xv & 6'h14)}};
      txn(xv, 6'd52, 1'b1, r, lat, rs);
      check($sformatf("e52a_x%0h", i), r, ex);
    end

    // backpressure plus input churn during RUN/DONE
    in_valid = 1'b1;
    x        = 6'h20;
    e        = 6'd2;
    add_en   = 1'b0;
    @(posedge clk); #1;
    x      = 6'h3F;
    e      = 6'h15;
    add_en = 1'b1;
    lat    = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 6);
    check("bp_y", y, 6'h30);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_y_hold", y, 6'h30);
      check("bp_ov_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_back_idle", in_ready, 1);
    check("bp_ov_clear", out_valid, 0);

    // abort mid-computation
    in_valid = 1'b1;
    x        = 6'h2D;
    e        = 6'd5;
    add_en   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_y", y, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    ov_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("abort_no_result", ov_seen, 0);

    txn(6'h02, 6'd1, 1'b0, r, lat, rs);
    check("post_rst_y", r, 6'h02);
    check("post_rst_lat", lat, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
